// File: rtl/alu_pkg.sv
// Shared definitions for the ALU time-share scheduler.
// Holds default operand/opcode widths, the opcode encoding passed through to
// the external ALU, and the scheduler FSM state encoding.
package alu_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned OPW_DEF   = 4;

    // Opcodes are forwarded unchecked; listed for reference by requesters.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_AND = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_EQ  = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_rr_pick2.sv
// Two-way round-robin picker, purely combinational.
// Ports:
//   req        in  2  request bits
//   last       in  1  id granted most recently
//   gnt_id     out 1  chosen requester (0 when nothing requests)
//   gnt_valid  out 1  some requester is being granted
module alu_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_id,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        // Alternate only under contention; a lone requester always wins.
        if (&req) begin
            gnt_id = ~last;
        end else begin
            gnt_id = req[1];
        end
    end

endmodule

// File: rtl/alu_share_sched.sv
// Time-shares one external combinational ALU between two requesters
// (0: main datapath, 1: branch/compare unit).
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready[1:0] per-requester request handshake
//   reqN_op/_a/_b            requester N opcode and operands
//   rsp_valid/rsp_ready[1:0] per-requester response handshake
//   rsp_result, rsp_zero     shared response payload, valid with rsp_valid
//   alu_r1/_r2/_op           registered operands/opcode to the ALU
//   alu_result, alu_zero     ALU outputs, captured in EXEC
//   busy                     high whenever not idle
// One op takes IDLE (accept) -> EXEC (ALU evaluates) -> RESP (hold until consumed).
module alu_share_sched
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned OPW   = OPW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_r1,
    output logic [WIDTH-1:0] alu_r2,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             gid_q, gid_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] r1_q, r1_d;
    logic [WIDTH-1:0] r2_q, r2_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic gnt_id;
    logic gnt_valid;

    alu_rr_pick2 u_pick (
        .req       (req_valid),
        .last      (last_q),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_d     = state_q;
        gid_d       = gid_q;
        last_d      = last_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        req_ready   = 2'b00;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    req_ready[gnt_id] = 1'b1;
                    gid_d             = gnt_id;
                    last_d            = gnt_id;
                    op_d              = gnt_id ? req1_op : req0_op;
                    r1_d              = gnt_id ? req1_a  : req0_a;
                    r2_d              = gnt_id ? req1_b  : req0_b;
                    state_d           = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d           = alu_result;
                zero_d             = alu_zero;
                rsp_valid_d        = 2'b00;
                rsp_valid_d[gid_q] = 1'b1;
                state_d            = ST_RESP;
            end
            ST_RESP: begin
                // Only the owning requester can release the response.
                if (rsp_ready[gid_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gid_q       <= 1'b0;
            last_q      <= 1'b1;
            r1_q        <= '0;
            r2_q        <= '0;
            op_q        <= '0;
            rsp_valid_q <= 2'b00;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gid_q       <= gid_d;
            last_q      <= last_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

    assign alu_r1     = r1_q;
    assign alu_r2     = r2_q;
    assign alu_op     = op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
